wb_uart: RTL

Wishbone classic slave that exposes an 8N1 UART through four 32-bit registers. It sits behind `wb_interconnect` as the responder on a slave port: it samples `STB`/`CYC` from the interconnect and answers with `ACK` and read data. Its serial pins go to the chip's UART pads. The transmitter is always present; the receiver is a compile-time option.

---
 rtl/wb_uart_pkg.sv | 28 ++
 rtl/uart_rx.sv | 104 ++++++++++
 rtl/wb_uart.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_pkg.sv
// rtl/wb_uart_pkg.sv - shared register offsets, STATUS bit indices and UART FSM states
// Contents: REG_* word offsets (ADR[3:2]), ST_* STATUS bit positions,
//           uart_state_t used by both TX and RX, clamp_div for BAUD writes.
package wb_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Divisors below 3 leave no room for the half-bit start check.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < 16'd3) ? 16'd3 : d;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: 2-flop synchronizer, RX FSM and bit counter
// Ports: clk_i, rst_i (async, active-high), div_i (bit period - 1), rx_i (async serial in),
//        data_o (last byte), done_o (one-cycle pulse per byte), frame_err_o (valid with done_o).
module uart_rx
    import wb_uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] div_i,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        done_o,
    output logic        frame_err_o
);

    logic [1:0]  sync_q;
    uart_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = div_i >> 1;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    // Line back high at mid-start: treat as a glitch, no flags.
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = div_i;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    cnt_d   = div_i;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    done_d  = 1'b1;
                    ferr_d  = ~rx_s;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_o      = shift_q;
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/wb_uart.sv
// rtl/wb_uart.sv - Wishbone classic slave exposing an 8N1 UART through four registers
// Ports: clk_i, rst_i (async, active-high); S_* Wishbone slave (ADR[3:2] decoded,
//        ACK one-cycle pulse, DAT_O valid only with ACK); uart_tx_o (idles high), uart_rx_i.
// Build option: WB_UART_RX_EN adds the receiver, RXDATA and STATUS bits 1-3.
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   S_DAT_I,
    input  logic [ADDR_WIDTH-1:0]   S_ADR_I,
    output logic [DATA_WIDTH-1:0]   S_DAT_O,
    input  logic                    S_WE_I,
    input  logic [DATA_WIDTH/8-1:0] S_SEL_I,
    input  logic                    S_STB_I,
    output logic                    S_ACK_O,
    input  logic                    S_CYC_I,
    output logic                    uart_tx_o,
    input  logic                    uart_rx_i
);

    logic                  ack_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic [15:0]           div_q;
    logic                  req, wr, rd, tx_wr;
    logic [1:0]            reg_sel;
    logic [3:0]            status;
    logic [7:0]            rx_data;
    logic                  rx_valid, rx_overrun, frame_err;
    logic                  unused_ok;

    uart_state_t tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q;

    // Masking with !ACK makes a held access commit once every two cycles.
    assign req     = S_STB_I & S_CYC_I & ~ack_q;
    assign wr      = req & S_WE_I;
    assign rd      = req & ~S_WE_I;
    assign reg_sel = S_ADR_I[3:2];
    assign tx_wr   = wr && (reg_sel == REG_TXDATA) && S_SEL_I[0];
    assign unused_ok = ^{S_ADR_I, S_DAT_I, S_SEL_I, uart_rx_i};

    always_comb begin
        status               = 4'd0;
        status[ST_TX_BUSY]    = (tx_state_q != IDLE);
        status[ST_RX_VALID]   = rx_valid;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_FRAME_ERR]  = frame_err;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_RXDATA: rdata[7:0]  = rx_data;
            REG_STATUS: rdata[3:0]  = status;
            REG_BAUD:   rdata[15:0] = div_q;
            default:    rdata       = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            div_q <= DEFAULT_DIV;
        end else begin
            ack_q <= req;
            dat_q <= rd ? rdata : '0;
            if (wr && (reg_sel == REG_BAUD) && (S_SEL_I[1:0] == 2'b11)) begin
                div_q <= clamp_div(S_DAT_I[15:0]);
            end
        end
    end

    assign S_ACK_O = ack_q;
    assign S_DAT_O = dat_q;

    // A TXDATA write outside IDLE is silently dropped.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            IDLE: begin
                if (tx_wr) begin
                    tx_state_d = START;
                    tx_cnt_d   = div_q;
                    tx_shift_d = S_DAT_I[7:0];
                end
            end
            START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = DATA;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_cnt_d   = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // The line is registered from the FSM state, so it trails the state by one
    // cycle and falls on the edge after the TXDATA commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= (tx_state_q == START) ? 1'b0 :
                          (tx_state_q == DATA)  ? tx_shift_q[0] : 1'b1;
        end
    end

    assign uart_tx_o = tx_q;

`ifdef WB_UART_RX_EN
    logic [7:0] rx_byte, rx_data_q;
    logic       rx_done, rx_ferr, rx_rd, st_wr;
    logic       rx_valid_q, rx_overrun_q, frame_err_q;

    uart_rx u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .div_i       (div_q),
        .rx_i        (uart_rx_i),
        .data_o      (rx_byte),
        .done_o      (rx_done),
        .frame_err_o (rx_ferr)
    );

    assign rx_rd = rd && (reg_sel == REG_RXDATA);
    assign st_wr = wr && (reg_sel == REG_STATUS) && S_SEL_I[0];

    // Clears are written first so a same-cycle byte completion wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (st_wr && S_DAT_I[ST_RX_OVERRUN]) rx_overrun_q <= 1'b0;
            if (st_wr && S_DAT_I[ST_FRAME_ERR])  frame_err_q  <= 1'b0;
            if (rx_rd) rx_valid_q <= 1'b0;
            if (rx_done) begin
                rx_data_q  <= rx_byte;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !rx_rd) rx_overrun_q <= 1'b1;
                if (rx_ferr) frame_err_q <= 1'b1;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign frame_err  = frame_err_q;
`else
    assign rx_data    = 8'd0;
    assign rx_valid   = 1'b0;
    assign rx_overrun = 1'b0;
    assign frame_err  = 1'b0;
`endif

endmodule
